// File: rtl/locked_reg_pkg.sv
// ============================================================================
// Module      : locked_reg_pkg
// Description : Shared types for the locked register bank. It defines the
//               lock FSM states, the privilege levels and the decoder that
//               turns trusted/untrusted into a privilege level.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package locked_reg_pkg;

  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  typedef enum logic [0:0] {
    PRIV_TRUSTED   = 1'b0,
    PRIV_UNTRUSTED = 1'b1
  } priv_e;

  // Only the single combination trusted=1 / untrusted=0 grants trust.
  // Both-high, both-low and untrusted alone all fail safe.
  function automatic priv_e decode_priv(input logic trusted, input logic untrusted);
    return (trusted && !untrusted) ? PRIV_TRUSTED : PRIV_UNTRUSTED;
  endfunction

endpackage

`default_nettype wire

// File: rtl/locked_reg_cell.sv
// ============================================================================
// Module      : locked_reg_cell
// Description : One configuration register and its sticky lock FSM.
// Ports       : Clk, resetn    - clock, synchronous active-low reset
//               we             - write enable for this register
//               d              - write data
//               lock_req       - lock request for this register
//               priv           - decoded privilege of the requester
//               q              - register contents
//               locked         - lock state
//               blocked        - the current write is refused (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module locked_reg_cell
  import locked_reg_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             Clk,
  input  logic             resetn,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  input  logic             lock_req,
  input  priv_e            priv,
  output logic [WIDTH-1:0] q,
  output logic             locked,
  output logic             blocked
);

  lock_state_e state;
  lock_state_e state_next;
  logic        commit;

  // LOCKED has no exit; only reset returns the cell to UNLOCKED.
  always_comb begin
    state_next = state;
    if (state == UNLOCKED && lock_req) begin
      state_next = LOCKED;
    end
  end

  // Qualify against the post-update lock state so that a lock arriving in
  // the same cycle as an untrusted write already blocks that write.
  always_comb begin
    commit  = we && ((state_next == UNLOCKED) || (priv == PRIV_TRUSTED));
    blocked = we && !commit;
  end

  always_ff @(posedge Clk) begin
    if (!resetn) begin
      state <= UNLOCKED;
      q     <= RESET_VAL;
    end else begin
      state <= state_next;
      if (commit) begin
        q <= d;
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule

`default_nettype wire

// File: rtl/locked_register_bank.sv
// ============================================================================
// Module      : locked_register_bank
// Description : Bank of NUM_REGS lockable configuration registers with
//               registered readback, write response pulses and tracking of
//               blocked writes.
// Ports       : Clk, resetn          - clock, synchronous active-low reset
//               write/wr_addr/Data_in - write request
//               Lock/lock_addr       - lock one register
//               lock_all             - lock every register
//               trusted/untrusted    - requester privilege
//               clr_viol             - clear viol_sticky (trusted only)
//               rd_addr/Data_out     - registered readback
//               lock_status          - per-register lock bits
//               wr_ack/wr_err        - one-cycle write responses
//               viol_count           - saturating blocked-write count
//               viol_sticky          - set by any blocked write
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module locked_register_bank
  import locked_reg_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               NUM_REGS  = 4,
  parameter int               ADDR_W    = $clog2(NUM_REGS),
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 8
) (
  input  logic              Clk,
  input  logic              resetn,
  input  logic              write,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  Data_in,
  input  logic              Lock,
  input  logic [ADDR_W-1:0] lock_addr,
  input  logic              lock_all,
  input  logic              trusted,
  input  logic              untrusted,
  input  logic              clr_viol,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  Data_out,
  output logic [NUM_REGS-1:0] lock_status,
  output logic              wr_ack,
  output logic              wr_err,
  output logic [CNT_W-1:0]  viol_count,
  output logic              viol_sticky
);

  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

  priv_e                priv;
  logic                 wr_addr_ok;
  logic                 rd_addr_ok;
  logic [NUM_REGS-1:0]  cell_blocked;
  logic                 wr_blocked;
  logic                 wr_commit;
  logic [WIDTH-1:0]     q_arr [NUM_REGS];

  assign priv       = decode_priv(trusted, untrusted);
  // Address checks only matter when NUM_REGS is not a power of two.
  assign wr_addr_ok = ({1'b0, wr_addr} < NUM_REGS_W);
  assign rd_addr_ok = ({1'b0, rd_addr} < NUM_REGS_W);

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cells
      logic cell_we;
      logic cell_lock;

      // An out-of-range lock_addr never matches any index, so it is ignored.
      assign cell_we   = write && (wr_addr == ADDR_W'(i));
      assign cell_lock = lock_all || (Lock && (lock_addr == ADDR_W'(i)));

      locked_reg_cell #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_cell (
        .Clk      (Clk),
        .resetn   (resetn),
        .we       (cell_we),
        .d        (Data_in),
        .lock_req (cell_lock),
        .priv     (priv),
        .q        (q_arr[i]),
        .locked   (lock_status[i]),
        .blocked  (cell_blocked[i])
      );
    end
  endgenerate

  // A write to a non-existent register is a violation regardless of privilege.
  assign wr_blocked = (|cell_blocked) || (write && !wr_addr_ok);
  assign wr_commit  = write && !wr_blocked;

  always_ff @(posedge Clk) begin
    if (!resetn) begin
      Data_out    <= '0;
      wr_ack      <= 1'b0;
      wr_err      <= 1'b0;
      viol_count  <= '0;
      viol_sticky <= 1'b0;
    end else begin
      // Samples the pre-write register value, so read-during-write sees old data.
      Data_out <= rd_addr_ok ? q_arr[rd_addr] : '0;
      wr_ack   <= wr_commit;
      wr_err   <= wr_blocked;
      if (wr_blocked && (viol_count != {CNT_W{1'b1}})) begin
        viol_count <= viol_count + 1'b1;
      end
      // A violation in the same cycle as a clear wins.
      if (wr_blocked) begin
        viol_sticky <= 1'b1;
      end else if (clr_viol && (priv == PRIV_TRUSTED)) begin
        viol_sticky <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
